pwm_fade_ctrl: RTL and testbench
================================

// Module: pwm_fade_ctrl
// PURPOSE
//  Sequences an 8-bit PWM channel through glitch-free duty-cycle ramps ("fades").
//  Accepts one fade command at a time on a valid/ready port, steps the duty toward the target
//  by a fixed amount every N PWM periods, and pulses done on arrival.
//  Duty changes take effect only at PWM period boundaries.
//  Sits between the Nios-facing register/CSR logic and the LED/motor PWM pin.
// PARAMETERS
//  DUTY_W  8  duty/counter width; PWM period = 2**DUTY_W clk cycles
//  HOLD_W  8  width of cmd_hold (periods to dwell per step, minus 1)
// PORTS
//  clk         in   1       clock
//  reset       in   1       synchronous, active-high reset
//  cmd_valid   in   1       fade command present
//  cmd_ready   out  1       block can accept a command (high only in IDLE, low while reset high)
//  cmd_target  in   DUTY_W  final duty
//  cmd_step    in   DUTY_W  duty increment per step; 0 = jump straight to target
//  cmd_hold    in   HOLD_W  extra periods to wait between steps (0 = step every period)
//  abort       in   1       stop ramp, freeze current duty
//  duty        out  DUTY_W  duty currently applied to the comparator
//  pwm_out     out  1       PWM output
//  period_end  out  1       1-cycle pulse on the last clk of each PWM period
//  busy        out  1       high while not IDLE
//  done        out  1       1-cycle pulse when duty reaches target
// BEHAVIOUR
//  Reset: cnt=0, duty=0, pwm_out=0, done=0, busy=0, period_end=0, state=IDLE; cmd_ready=0 while reset high.
//  PWM core: cnt increments every clk, wraps 2**DUTY_W-1 -> 0; period_end=(cnt==max).
//   pwm_out registered: pwm_out <= (duty > cnt).
//   duty=0 gives constant 0; duty=max gives high max/2**DUTY_W of the period (never 100%).
//  Handshake: accept on cmd_valid & cmd_ready (same edge); latch target, step, hold; hold_cnt<=cmd_hold.
//   No acceptance outside IDLE.
//  FSM states: IDLE, RAMP, FINISH.
//   IDLE -> RAMP on accept if target!=duty; IDLE -> FINISH on accept if target==duty
//   (done pulses the next cycle, duty unchanged).
//   RAMP: on each period_end: if hold_cnt!=0, hold_cnt--. Else apply step and hold_cnt<=hold.
//    Step up (target>duty): duty <= (target-duty <= step) ? target : duty+step.
//    Step down (target<duty): duty <= (duty-target <= step) ? target : duty-step.
//    step==0: duty <= target.
//    Compute in DUTY_W+1 bits; never overshoot or wrap.
//   duty written only on the period_end cycle, so the comparator sees a new value from cnt=0.
//   RAMP -> FINISH on the update that makes duty==target.
//   FINISH: done=1 for one cycle -> IDLE.
//  abort: in RAMP, -> IDLE next edge, duty frozen, no done pulse.
//   If abort coincides with an update period_end, abort wins and the update is not applied.
//   abort is ignored in IDLE and FINISH.
//  cnt free-runs regardless of FSM; commands do not realign the period.
//  reset mid-ramp: everything returns to reset values on that edge; the ramp is discarded.
//  Latency: the first step lands on the (cmd_hold+1)-th period_end after accept.
// STRUCTURE
//  Shared package pwm_ctrl_pkg: state enum {IDLE,RAMP,FINISH}, DUTY_W default, localparam CNT_MAX.
//  Sub-module pwm_core (cnt, period_end, registered compare -> pwm_out), input duty.
//  pwm_fade_ctrl holds the FSM, command latches, hold counter and step arithmetic.
// TESTING
//  1 reset 5 clk -> duty=0, pwm_out=0, busy=0; cmd_ready=1 the first cycle after reset falls.
//  2 target=64, step=16, hold=0 from 0 -> duty 16,32,48,64 at 4 consecutive period_ends;
//    done pulse 1 clk after the 4th; then pwm_out high exactly 64 clk per 256.
//  3 target=10, step=4, hold=1 from 0 -> duty 4,8,10 on every 2nd period_end (no overshoot); cmd_ready low until done.
//  4 duty=64, target=0, step=100 -> single update to 0 at the first period_end; pwm_out constant 0 afterwards.
//    Then target=200, step=0 -> jump to 200 at the next period_end.
//  5 target==duty (64) -> no period wait; done 1 clk after accept.
//    cmd_valid held while busy is not accepted.
//  6 abort on the same clk as an update period_end mid-ramp -> duty unchanged, no done, IDLE.
//    reset mid-ramp -> duty=0, pwm_out=0 next edge.

Source files
------------

// File: rtl/pwm_ctrl_pkg.sv
// Shared types and defaults for the PWM fade controller.
package pwm_ctrl_pkg;

    localparam int DUTY_W_DEF = 8;
    localparam int HOLD_W_DEF = 8;
    // Last counter value of a period at the default width.
    localparam logic [DUTY_W_DEF-1:0] CNT_MAX = {DUTY_W_DEF{1'b1}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RAMP   = 2'd1,
        FINISH = 2'd2
    } fade_state_t;

endpackage

// File: rtl/pwm_core.sv
// Free-running PWM counter with a registered duty compare.
// The counter never realigns; period_end marks its last value.
module pwm_core
    import pwm_ctrl_pkg::*;
#(
    parameter int DUTY_W = DUTY_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DUTY_W-1:0] duty,
    output logic              period_end,
    output logic              pwm_out
);

    logic [DUTY_W-1:0] cnt;

    // Counter wraps naturally at 2**DUTY_W; output is a registered compare so it is glitch-free.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            pwm_out <= 1'b0;
        end else begin
            cnt     <= cnt + 1'b1;
            pwm_out <= (duty > cnt);
        end
    end

    assign period_end = (cnt == {DUTY_W{1'b1}});

endmodule

// File: rtl/pwm_fade_ctrl.sv
// Fade sequencer: accepts one ramp command at a time and steps the PWM duty
// toward the target at period boundaries, pulsing done on arrival.
module pwm_fade_ctrl
    import pwm_ctrl_pkg::*;
#(
    parameter int DUTY_W = DUTY_W_DEF,
    parameter int HOLD_W = HOLD_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DUTY_W-1:0] cmd_target,
    input  logic [DUTY_W-1:0] cmd_step,
    input  logic [HOLD_W-1:0] cmd_hold,
    input  logic              abort,
    output logic [DUTY_W-1:0] duty,
    output logic              pwm_out,
    output logic              period_end,
    output logic              busy,
    output logic              done
);

    fade_state_t       state, state_nxt;
    logic [DUTY_W-1:0] tgt_q, step_q;
    logic [HOLD_W-1:0] hold_q, hold_cnt;
    logic [DUTY_W:0]   diff_up, diff_dn;
    logic [DUTY_W-1:0] duty_step;
    logic              accept, ramp_tick, step_due;

    pwm_core #(.DUTY_W(DUTY_W)) u_core (
        .clk        (clk),
        .reset      (reset),
        .duty       (duty),
        .period_end (period_end),
        .pwm_out    (pwm_out)
    );

    assign accept    = cmd_valid & cmd_ready;
    // A period boundary inside a live ramp; abort suppresses any update on it.
    assign ramp_tick = (state == RAMP) & period_end & ~abort;
    assign step_due  = ramp_tick & (hold_cnt == '0);

    // Next duty value, computed one bit wider so the distance never wraps and the step never overshoots.
    always_comb begin
        diff_up   = {1'b0, tgt_q} - {1'b0, duty};
        diff_dn   = {1'b0, duty} - {1'b0, tgt_q};
        duty_step = duty;
        if (step_q == '0)
            duty_step = tgt_q;
        else if (tgt_q > duty)
            duty_step = (diff_up <= {1'b0, step_q}) ? tgt_q : duty + step_q;
        else if (tgt_q < duty)
            duty_step = (diff_dn <= {1'b0, step_q}) ? tgt_q : duty - step_q;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (cmd_target == duty) ? FINISH : RAMP;
            RAMP: begin
                if (abort)                               state_nxt = IDLE;
                else if (step_due && duty_step == tgt_q) state_nxt = FINISH;
            end
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM-decoded outputs; ready is forced low while reset is held.
    always_comb begin
        cmd_ready = (state == IDLE) & ~reset;
        busy      = (state != IDLE);
        done      = (state == FINISH);
    end

    // Command latches, dwell counter and duty register; duty only moves on a period boundary.
    always_ff @(posedge clk) begin
        if (reset) begin
            duty     <= '0;
            tgt_q    <= '0;
            step_q   <= '0;
            hold_q   <= '0;
            hold_cnt <= '0;
        end else if (accept) begin
            tgt_q    <= cmd_target;
            step_q   <= cmd_step;
            hold_q   <= cmd_hold;
            hold_cnt <= cmd_hold;
        end else if (ramp_tick) begin
            if (hold_cnt != '0) begin
                hold_cnt <= hold_cnt - 1'b1;
            end else begin
                duty     <= duty_step;
                hold_cnt <= hold_q;
            end
        end
    end

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Self-checking bench for pwm_fade_ctrl: directed scenarios with literal
// expectations plus randomized fades checked against a behavioural model.
module tb_pwm_fade_ctrl;

    localparam int PER = 256;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] cmd_target = '0;
    logic [7:0] cmd_step = '0;
    logic [7:0] cmd_hold = '0;
    logic       cmd_ready, pwm_out, period_end, busy, done;
    logic [7:0] duty;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pwm_fade_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_target (cmd_target),
        .cmd_step   (cmd_step),
        .cmd_hold   (cmd_hold),
        .abort      (abort),
        .duty       (duty),
        .pwm_out    (pwm_out),
        .period_end (period_end),
        .busy       (busy),
        .done       (done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Time since reset modulo the period, the applied duty, whether a fade is
    // in flight, how many period ends remain before the next step lands, and
    // whether this cycle carries the arrival pulse.
    int m_cnt, m_duty, m_tgt, m_step, m_hold, m_wait, m_dist, m_nd;
    bit m_pwm, m_ramping, m_done, m_live, m_pe, m_idle, m_fin;

    always @(posedge clk) begin
        if (reset) begin
            m_cnt = 0; m_duty = 0; m_pwm = 0; m_ramping = 0; m_done = 0; m_live = 1;
        end else begin
            m_pe   = (m_cnt == PER - 1);
            m_idle = !m_ramping && !m_done;
            m_pwm  = (m_duty > m_cnt);
            m_cnt  = (m_cnt + 1) % PER;
            m_fin  = 0;
            if (m_idle && cmd_valid) begin
                m_tgt = cmd_target; m_step = cmd_step; m_hold = cmd_hold;
                if (m_tgt == m_duty) m_fin = 1;
                else begin m_ramping = 1; m_wait = m_hold + 1; end
            end else if (m_ramping) begin
                if (abort) m_ramping = 0;
                else if (m_pe) begin
                    m_wait--;
                    if (m_wait == 0) begin
                        m_dist = (m_tgt > m_duty) ? m_tgt - m_duty : m_duty - m_tgt;
                        if (m_step == 0 || m_dist <= m_step) m_nd = m_tgt;
                        else m_nd = (m_tgt > m_duty) ? m_duty + m_step : m_duty - m_step;
                        m_duty = m_nd;
                        if (m_nd == m_tgt) begin m_ramping = 0; m_fin = 1; end
                        else m_wait = m_hold + 1;
                    end
                end
            end
            m_done = m_fin;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_live) begin
            check("duty",       32'(duty),       32'(m_duty));
            check("pwm_out",    32'(pwm_out),    32'(m_pwm));
            check("period_end", 32'(period_end), 32'(m_cnt == PER - 1));
            check("busy",       32'(busy),       32'(m_ramping || m_done));
            check("done",       32'(done),       32'(m_done));
            check("cmd_ready",  32'(cmd_ready),  32'(!reset && !(m_ramping || m_done)));
        end
    end

    // ---------------- helpers ----------------
    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_idle(input int bound);
        int k = 0;
        while ((m_ramping || m_done) && k < bound) begin tick(1); k++; end
        if (m_ramping || m_done) begin
            n_checks++; n_fail++;
            $display("FAIL wait_idle: still busy after %0d cycles", bound);
        end
    endtask

    task automatic send(input int t, input int s, input int h);
        wait_idle(6000);
        cmd_target = 8'(t); cmd_step = 8'(s); cmd_hold = 8'(h); cmd_valid = 1'b1;
        tick(1);
        cmd_valid = 1'b0;
    endtask

    // Advance to just after the next period-end edge.
    task automatic wait_pe();
        int k = 0;
        while (m_cnt != PER - 1 && k < 2 * PER) begin tick(1); k++; end
        if (m_cnt != PER - 1) begin
            n_checks++; n_fail++;
            $display("FAIL wait_pe: no period end within %0d cycles", 2 * PER);
        end
        tick(1);
    endtask

    task automatic count_high(input string name, input int exp);
        int hi = 0;
        for (int i = 0; i < PER; i++) begin hi += int'(pwm_out); tick(1); end
        check(name, 32'(hi), 32'(exp));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // 1: reset
        tick(5);
        check("rst_duty",  32'(duty),      0);
        check("rst_pwm",   32'(pwm_out),   0);
        check("rst_busy",  32'(busy),      0);
        check("rst_ready", 32'(cmd_ready), 0);
        reset = 1'b0;
        tick(1);
        check("ready_after_rst", 32'(cmd_ready), 1);
        tick(37);

        // 2: 0 -> 64 in steps of 16, no dwell
        send(64, 16, 0);
        for (int k = 1; k <= 4; k++) begin
            wait_pe();
            check("s2_duty", 32'(duty), 32'(16 * k));
        end
        check("s2_done", 32'(done), 1);
        tick(1);
        check("s2_done_clr", 32'(done), 0);
        while (m_cnt != 1) tick(1);
        count_high("s2_hi64", 64);

        // 4a: 64 -> 0 in a single oversized step
        send(0, 100, 0);
        wait_pe();
        check("s4_duty0", 32'(duty), 0);
        check("s4_done", 32'(done), 1);
        tick(2);
        count_high("s4_hi0", 0);

        // 3: 0 -> 10 step 4, dwell 1 extra period
        send(10, 4, 1);
        wait_pe();
        check("s3_hold_duty", 32'(duty), 0);
        check("s3_ready_lo", 32'(cmd_ready), 0);
        wait_pe(); check("s3_d4", 32'(duty), 4);
        wait_pe(); wait_pe(); check("s3_d8", 32'(duty), 8);
        check("s3_ready_lo2", 32'(cmd_ready), 0);
        wait_pe(); wait_pe(); check("s3_d10", 32'(duty), 10);
        check("s3_done", 32'(done), 1);

        // 4b: step 0 jumps straight to target
        send(200, 0, 0);
        wait_pe();
        check("s4_jump", 32'(duty), 200);

        // 5: target equals duty -> done right after accept
        send(200, 5, 0);
        check("s5_done", 32'(done), 1);
        check("s5_duty", 32'(duty), 200);
        tick(1);
        check("s5_idle", 32'(busy), 0);
        // a command held while busy must not be accepted
        send(100, 20, 0);
        cmd_target = 8'd7; cmd_step = 8'd1; cmd_valid = 1'b1;
        tick(20);
        cmd_valid = 1'b0;
        wait_idle(6000);
        check("s5_busy_ignored", 32'(duty), 100);

        // 6: abort on an update period end
        send(0, 8, 0);
        wait_pe(); wait_pe();
        check("s6_pre", 32'(duty), 84);
        while (m_cnt != PER - 1) tick(1);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        check("s6_frozen", 32'(duty), 84);
        check("s6_busy",   32'(busy), 0);
        check("s6_nodone", 32'(done), 0);
        tick(300);
        check("s6_still", 32'(duty), 84);

        // reset mid-ramp
        send(255, 8, 0);
        wait_pe();
        check("s6_ramp", 32'(duty), 92);
        tick(30);
        reset = 1'b1;
        tick(1);
        check("s6_rst_duty", 32'(duty), 0);
        check("s6_rst_pwm",  32'(pwm_out), 0);
        check("s6_rst_busy", 32'(busy), 0);
        reset = 1'b0;
        tick(3);

        // randomized fades, occasional aborts
        for (int i = 0; i < 12; i++) begin
            int t, s, h;
            t = $urandom_range(0, 255);
            s = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(64, 255);
            h = $urandom_range(0, 1);
            send(t, s, h);
            if ($urandom_range(0, 3) == 0) begin
                tick($urandom_range(1, 600));
                abort = 1'b1;
                tick(1);
                abort = 1'b0;
            end
            wait_idle(6000);
            tick($urandom_range(0, 40));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
